// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 frame sequencer.
// Contents: APB register word indices (PADDR[4:2]), CTRL/STATUS bit positions,
// the pixel width, and the sequencer state enum.
package ws2812_pkg;

    localparam int unsigned PIX_W = 24;

    // Register word indices as decoded from PADDR[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;   // 0x00
    localparam logic [2:0] REG_NPIX   = 3'd1;   // 0x04
    localparam logic [2:0] REG_DATA   = 3'd2;   // 0x08
    localparam logic [2:0] REG_STATUS = 3'd3;   // 0x0C

    // CTRL bit positions
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_FIFO_CLR = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    // STATUS bit positions
    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_EMPTY    = 1;
    localparam int unsigned ST_FULL     = 2;
    localparam int unsigned ST_OVF      = 3;
    localparam int unsigned ST_UNDERRUN = 4;
    localparam int unsigned ST_DONE     = 5;
    localparam int unsigned ST_LVL_LSB  = 8;
    localparam int unsigned ST_LVL_MSB  = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BIT,
        S_LATCH
    } state_t;

endpackage

// File: rtl/ws2812_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO.
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata read
// side (rdata shows the head entry); clr empties the FIFO and overrides a
// same-cycle push/pop; full, empty and level (0..DEPTH) status.
// A push while full is dropped (full is judged before any same-cycle pop).
module ws2812_pixel_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clr,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage; no reset needed, occupancy defines validity
    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// APB3 WS2812 LED-strip frame sequencer.
// Pixels (24-bit GRB) are pushed into a FIFO via DATA, NPIX sets the frame
// length and CTRL.START launches a frame: each pixel is popped and sent MSB
// first as PWM bits of T_BIT cycles on LED, then LED is held low for T_RESET.
// Ports: PCLK, PRESET (sync active-high), APB3 slave (PSEL, PENABLE, PWRITE,
// PADDR[4:2] decoded, PWDATA, PRDATA combinational, PREADY=1, PSLVERR=0),
// LED (registered strip data), IRQ (registered, only with WS2812_SEQ_IRQ_EN).
// Optional feature macro: WS2812_SEQ_IRQ_EN adds IRQ and CTRL bit3 IRQ_EN.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned T_BIT      = 125,
    parameter int unsigned T1H        = 80,
    parameter int unsigned T0H        = 40,
    parameter int unsigned T_RESET    = 6000,
    parameter int unsigned NPIX_W     = 10
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
`ifdef WS2812_SEQ_IRQ_EN
    output logic        IRQ,
`endif
    output logic        LED
);

    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_MAX = (T_RESET > T_BIT) ? T_RESET : T_BIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // APB decode
    logic       wr_en;
    logic [2:0] idx;
    logic       wr_ctrl;
    logic       wr_npix;
    logic       wr_data;
    logic       wr_status;

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign idx       = PADDR[4:2];
    assign wr_ctrl   = wr_en && (idx == REG_CTRL);
    assign wr_npix   = wr_en && (idx == REG_NPIX);
    assign wr_data   = wr_en && (idx == REG_DATA);
    assign wr_status = wr_en && (idx == REG_STATUS);
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;

    logic unused_apb;
    assign unused_apb = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:24]};

    // Control/status registers
    logic              start_q;
    logic [NPIX_W-1:0] npix;
    logic              ovf;
    logic              underrun;
    logic              done;
    logic              ovf_nxt;
    logic              underrun_nxt;
    logic              done_nxt;

    // Sequencer state
    state_t            state;
    logic [PIX_W-1:0]  sr;
    logic [4:0]        bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic [NPIX_W-1:0] pix_cnt;
    logic [NPIX_W-1:0] pix_next;
    logic [NPIX_W-1:0] npix_run;
    logic              led_q;

    // FIFO interface
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clr;
    logic [PIX_W-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    assign fifo_push = wr_data;
    assign fifo_clr  = wr_ctrl & PWDATA[CTRL_FIFO_CLR];
    assign fifo_pop  = (state == S_LOAD) & ~fifo_empty;
    assign pix_next  = pix_cnt + NPIX_W'(1);
    assign LED       = led_q;

    ws2812_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (fifo_push),
        .wdata (PWDATA[PIX_W-1:0]),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // PWM high phase: LED is high while the in-bit counter is below the high time
    function automatic logic pwm_level(input logic b, input logic [CNT_W-1:0] c);
        return c < (b ? CNT_W'(T1H) : CNT_W'(T0H));
    endfunction

    // Sticky flag update: hardware set wins over a same-cycle write-1-to-clear
    always_comb begin
        ovf_nxt      = ovf;
        underrun_nxt = underrun;
        done_nxt     = done;
        if (wr_status) begin
            if (PWDATA[ST_OVF])      ovf_nxt      = 1'b0;
            if (PWDATA[ST_UNDERRUN]) underrun_nxt = 1'b0;
            if (PWDATA[ST_DONE])     done_nxt     = 1'b0;
        end
        if (fifo_push && fifo_full && !fifo_clr)           ovf_nxt      = 1'b1;
        if (state == S_LOAD && fifo_empty)                 underrun_nxt = 1'b1;
        if (state == S_LATCH && cnt == CNT_W'(T_RESET-1))  done_nxt     = 1'b1;
    end

`ifdef WS2812_SEQ_IRQ_EN
    logic irq_en;
    logic irq_en_nxt;
    logic irq_q;

    assign irq_en_nxt = wr_ctrl ? PWDATA[CTRL_IRQ_EN] : irq_en;
    assign IRQ        = irq_q;

    // Level interrupt built from next-cycle flag values so it tracks the flags
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            irq_en <= irq_en_nxt;
            irq_q  <= irq_en_nxt & (done_nxt | underrun_nxt | ovf_nxt);
        end
    end
`endif

    // Register file
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            start_q  <= 1'b0;
            npix     <= '0;
            ovf      <= 1'b0;
            underrun <= 1'b0;
            done     <= 1'b0;
        end else begin
            start_q  <= wr_ctrl & PWDATA[CTRL_START];
            if (wr_npix) npix <= PWDATA[NPIX_W-1:0];
            ovf      <= ovf_nxt;
            underrun <= underrun_nxt;
            done     <= done_nxt;
        end
    end

    // Frame sequencer; LED is computed from the next counter/bit values so the
    // registered output lines up with the bit period
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_IDLE;
            led_q    <= 1'b0;
            sr       <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            pix_cnt  <= '0;
            npix_run <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    led_q   <= 1'b0;
                    cnt     <= '0;
                    pix_cnt <= '0;
                    if (start_q && npix != '0) begin
                        npix_run <= npix;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                    if (!fifo_empty) begin
                        sr      <= fifo_rdata;
                        bit_idx <= 5'(PIX_W - 1);
                        led_q   <= pwm_level(fifo_rdata[PIX_W-1], '0);
                        state   <= S_BIT;
                    end else begin
                        led_q <= 1'b0;
                        state <= S_LATCH;
                    end
                end
                S_BIT: begin
                    if (cnt == CNT_W'(T_BIT - 1)) begin
                        cnt <= '0;
                        if (bit_idx == '0) begin
                            led_q   <= 1'b0;
                            pix_cnt <= pix_next;
                            state   <= (pix_next < npix_run) ? S_LOAD : S_LATCH;
                        end else begin
                            sr      <= {sr[PIX_W-2:0], 1'b0};
                            bit_idx <= bit_idx - 5'(1);
                            led_q   <= pwm_level(sr[PIX_W-2], '0);
                        end
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        led_q <= pwm_level(sr[PIX_W-1], cnt + CNT_W'(1));
                    end
                end
                S_LATCH: begin
                    led_q <= 1'b0;
                    if (cnt == CNT_W'(T_RESET - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    led_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read mux; reads have no side effects
    always_comb begin
        PRDATA = '0;
        case (idx)
            REG_CTRL: begin
`ifdef WS2812_SEQ_IRQ_EN
                PRDATA[CTRL_IRQ_EN] = irq_en;
`endif
            end
            REG_NPIX: PRDATA[NPIX_W-1:0] = npix;
            REG_STATUS: begin
                PRDATA[ST_BUSY]                = (state != S_IDLE);
                PRDATA[ST_EMPTY]               = fifo_empty;
                PRDATA[ST_FULL]                = fifo_full;
                PRDATA[ST_OVF]                 = ovf;
                PRDATA[ST_UNDERRUN]            = underrun;
                PRDATA[ST_DONE]                = done;
                PRDATA[ST_LVL_MSB:ST_LVL_LSB]  = 8'(fifo_level);
            end
            default: PRDATA = '0;
        endcase
    end

endmodule
